muldiv_unit: RTL

Iterative RV32M multiply/divide execution unit for the thoth-rv32 core. It consumes the two register-file read operands (rs1/rs2 data) plus funct3 and destination index. It computes the result over multiple cycles and drives a single-cycle write request toward the register file write port (rd index, data, write enable). The core stalls on `busy_o`.

---
 rtl/muldiv_unit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative RV32M multiply/divide execution unit
// Shift-add multiply and restoring divide on operand magnitudes, with sign fix-up after 32 steps.
module muldiv_unit (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        start_i,
  input  logic        kill_i,
  input  logic [2:0]  funct3_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic [4:0]  rd_idx_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic [4:0]  rd_idx_o,
  output logic        wen_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q;
  logic [2:0]  funct3_q;
  logic        sa_q, sb_q;
  logic [31:0] a_mag_q, b_mag_q;
  logic [5:0]  cnt_q;
  logic [63:0] prod_q;
  logic [31:0] rem_q, quot_q;

  logic        sign_a, sign_b;
  logic [31:0] a_mag, b_mag;
  logic        div_by_zero, div_overflow, special;
  logic [31:0] special_result;

  always_comb begin
    sign_a = 1'b0;
    sign_b = 1'b0;
    case (funct3_i)
      3'b001, 3'b100, 3'b110: begin
        sign_a = rs1_data_i[31];
        sign_b = rs2_data_i[31];
      end
      3'b010:  sign_a = rs1_data_i[31];
      default: ;
    endcase
  end

  assign a_mag = sign_a ? (32'd0 - rs1_data_i) : rs1_data_i;
  assign b_mag = sign_b ? (32'd0 - rs2_data_i) : rs2_data_i;

  assign div_by_zero  = funct3_i[2] && (rs2_data_i == 32'd0);
  assign div_overflow = funct3_i[2] && !funct3_i[0] &&
                        (rs1_data_i == 32'h8000_0000) && (rs2_data_i == 32'hFFFF_FFFF);
  assign special      = div_by_zero || div_overflow;
  // funct3[1] separates REM/REMU from DIV/DIVU
  assign special_result = div_by_zero ? (funct3_i[1] ? rs1_data_i : 32'hFFFF_FFFF)
                                      : (funct3_i[1] ? 32'd0 : 32'h8000_0000);

  // Product accumulator keeps the unconsumed multiplier bits in its low half
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  assign mul_sum   = {1'b0, prod_q[63:32]} + (prod_q[0] ? {1'b0, a_mag_q} : 33'd0);
  assign div_shift = {rem_q, quot_q[31]};
  assign div_ge    = (div_shift >= {1'b0, b_mag_q});

  logic [63:0] prod_fix;
  logic [31:0] quot_fix, rem_fix, fix_result;
  assign prod_fix = (sa_q ^ sb_q) ? (64'd0 - prod_q) : prod_q;
  assign quot_fix = (sa_q ^ sb_q) ? (32'd0 - quot_q) : quot_q;
  assign rem_fix  = sa_q ? (32'd0 - rem_q) : rem_q;

  always_comb begin
    fix_result = rem_fix;
    case (funct3_q)
      3'b000:                 fix_result = prod_fix[31:0];
      3'b001, 3'b010, 3'b011: fix_result = prod_fix[63:32];
      3'b100, 3'b101:         fix_result = quot_fix;
      default:                fix_result = rem_fix;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q  <= S_IDLE;
      funct3_q <= 3'd0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_mag_q  <= 32'd0;
      b_mag_q  <= 32'd0;
      cnt_q    <= 6'd0;
      prod_q   <= 64'd0;
      rem_q    <= 32'd0;
      quot_q   <= 32'd0;
      result_o <= 32'd0;
      rd_idx_o <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start_i && !kill_i) begin
            funct3_q <= funct3_i;
            sa_q     <= sign_a;
            sb_q     <= sign_b;
            a_mag_q  <= a_mag;
            b_mag_q  <= b_mag;
            cnt_q    <= 6'd0;
            prod_q   <= {32'd0, b_mag};
            rem_q    <= 32'd0;
            quot_q   <= a_mag;
            rd_idx_o <= rd_idx_i;
            if (special) begin
              result_o <= special_result;
              state_q  <= S_DONE;
            end else begin
              state_q  <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill_i) begin
            state_q <= S_IDLE;
          end else begin
            cnt_q <= cnt_q + 6'd1;
            if (funct3_q[2]) begin
              rem_q  <= div_ge ? (div_shift[31:0] - b_mag_q) : div_shift[31:0];
              quot_q <= {quot_q[30:0], div_ge};
            end else begin
              prod_q <= {mul_sum, prod_q[31:1]};
            end
            if (cnt_q == 6'd31) state_q <= S_FIX;
          end
        end
        S_FIX: begin
          if (kill_i) begin
            state_q <= S_IDLE;
          end else begin
            result_o <= fix_result;
            state_q  <= S_DONE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q != S_IDLE);
  assign done_o = (state_q == S_DONE);
  assign wen_o  = done_o && (rd_idx_o != 5'd0);

endmodule
